// File: rtl/vdp_sprite_pkg.sv
// Shared types for the sprite line renderer: FSM states, divide-table latency, tag record.
// Pure declarations.
package vdp_sprite_pkg;

    localparam int DT_LATENCY = 3;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DRAIN,
        ST_DONE
    } state_t;

    typedef struct packed {
        logic       valid;
        logic [8:0] dest;
    } tag_t;

endpackage

// File: rtl/vdp_sprite_occupancy.sv
// Per-line pixel occupancy bitmap: combinational test, registered set, sticky collision.
// No backpressure; a request is answered in the same cycle.
module vdp_sprite_occupancy (
    input  logic       clk,
    input  logic       reset,
    input  logic       clear,
    input  logic       req,
    input  logic [7:0] addr,
    output logic       grant,
    output logic       collision
);

    logic [255:0] bitmap;

    assign grant = req && !bitmap[addr];

    always_ff @(posedge clk) begin
        if (reset) begin
            bitmap    <= '0;
            collision <= 1'b0;
        end else begin
            // A grant in the clearing cycle still marks its pixel as taken.
            if (clear) begin
                bitmap <= '0;
            end
            if (grant) begin
                bitmap[addr] <= 1'b1;
            end
            collision <= clear ? 1'b0 : (collision || (req && bitmap[addr]));
        end
    end

endmodule

// File: rtl/vdp_sprite_line_renderer.sv
// Renders one sprite into the line buffer by sweeping the divide table; dot write lands
// DT_LATENCY+1 cycles after its offset is issued. No backpressure on the line buffer.
module vdp_sprite_line_renderer
    import vdp_sprite_pkg::*;
#(
    parameter int PAT_W   = 16,
    parameter int COLOR_W = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               line_clear,
    input  logic               start,
    input  logic [8:0]         sprite_x,
    input  logic [COLOR_W-1:0] sprite_color,
    input  logic [PAT_W-1:0]   pattern,
    input  logic [7:0]         mgx,
    input  logic [1:0]         bit_shift,
    output logic               busy,
    output logic               done,
    output logic [7:0]         dt_x,
    output logic [7:0]         dt_reg_mgx,
    output logic [1:0]         dt_bit_shift,
    input  logic [6:0]         dt_sample_x,
    input  logic               dt_overflow,
    output logic               lb_we,
    output logic [7:0]         lb_addr,
    output logic [COLOR_W-1:0] lb_wdata,
    output logic               collision
);

    localparam int         IDX_W   = $clog2(PAT_W);
    localparam logic [6:0] PAT_LIM = 7'(PAT_W);

    state_t             state;
    logic [8:0]         lat_x;
    logic [COLOR_W-1:0] lat_color;
    logic [PAT_W-1:0]   lat_pat;
    logic               issue_vld;
    tag_t               tags [DT_LATENCY];

    tag_t               cur;
    logic [8:0]         issue_dest;
    logic               issue_last;
    logic               kill;
    logic               dot_vld;
    logic [IDX_W-1:0]   pat_idx;
    logic               opaque;
    logic               grant;
    logic               younger_vld;

    assign cur        = tags[DT_LATENCY-1];
    assign issue_dest = lat_x + {1'b0, dt_x};
    assign issue_last = (issue_dest >= 9'd255) || (dt_x == 8'hFF);
    // The first out-of-pattern result ends the sprite and squashes everything behind it.
    assign kill       = cur.valid && (dt_overflow || (dt_sample_x >= PAT_LIM));
    assign dot_vld    = cur.valid && !kill && !cur.dest[8];
    assign pat_idx    = IDX_W'(PAT_W - 1) - dt_sample_x[IDX_W-1:0];
    assign opaque     = dot_vld && lat_pat[pat_idx] && (lat_color != '0);

    always_comb begin
        younger_vld = 1'b0;
        for (int i = 0; i < DT_LATENCY - 1; i++) begin
            younger_vld = younger_vld | tags[i].valid;
        end
    end

    vdp_sprite_occupancy u_occupancy (
        .clk       (clk),
        .reset     (reset),
        .clear     (line_clear),
        .req       (opaque),
        .addr      (cur.dest[7:0]),
        .grant     (grant),
        .collision (collision)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= ST_IDLE;
            busy         <= 1'b0;
            done         <= 1'b0;
            dt_x         <= '0;
            dt_reg_mgx   <= '0;
            dt_bit_shift <= '0;
            lb_we        <= 1'b0;
            lb_addr      <= '0;
            lb_wdata     <= '0;
            lat_x        <= '0;
            lat_color    <= '0;
            lat_pat      <= '0;
            issue_vld    <= 1'b0;
            for (int i = 0; i < DT_LATENCY; i++) begin
                tags[i] <= '0;
            end
        end else begin
            lb_we <= grant;
            if (grant) begin
                lb_addr  <= cur.dest[7:0];
                lb_wdata <= lat_color;
            end

            tags[0] <= '{valid: issue_vld && !kill, dest: issue_dest};
            for (int i = 1; i < DT_LATENCY; i++) begin
                tags[i] <= kill ? '0 : tags[i-1];
            end

            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        lat_x        <= sprite_x;
                        lat_color    <= sprite_color;
                        lat_pat      <= pattern;
                        dt_reg_mgx   <= mgx;
                        dt_bit_shift <= bit_shift;
                        dt_x         <= '0;
                        issue_vld    <= 1'b1;
                        busy         <= 1'b1;
                        state        <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (kill || issue_last) begin
                        issue_vld <= 1'b0;
                        state     <= ST_DRAIN;
                    end else begin
                        dt_x <= dt_x + 8'd1;
                    end
                end
                ST_DRAIN: begin
                    if (kill || !younger_vld) begin
                        state <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    busy  <= 1'b0;
                    done  <= 1'b1;
                    state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_vdp_sprite_line_renderer.sv
// Bench for vdp_sprite_line_renderer: divide-table model sample_x = x>>1, overflow at x >= 32;
// expected line-buffer writes are queued at start and popped as the DUT writes.
module tb_vdp_sprite_line_renderer;

    logic       clk = 1'b0;
    logic       reset;
    logic       line_clear;
    logic       start;
    logic [8:0] sprite_x;
    logic [3:0] sprite_color;
    logic [15:0] pattern;
    logic [7:0] mgx;
    logic [1:0] bit_shift;
    logic       busy;
    logic       done;
    logic [7:0] dt_x;
    logic [7:0] dt_reg_mgx;
    logic [1:0] dt_bit_shift;
    logic [6:0] dt_sample_x;
    logic       dt_overflow;
    logic       lb_we;
    logic [7:0] lb_addr;
    logic [3:0] lb_wdata;
    logic       collision;

    always #5 clk = ~clk;

    vdp_sprite_line_renderer #(.PAT_W(16), .COLOR_W(4)) dut (
        .clk          (clk),
        .reset        (reset),
        .line_clear   (line_clear),
        .start        (start),
        .sprite_x     (sprite_x),
        .sprite_color (sprite_color),
        .pattern      (pattern),
        .mgx          (mgx),
        .bit_shift    (bit_shift),
        .busy         (busy),
        .done         (done),
        .dt_x         (dt_x),
        .dt_reg_mgx   (dt_reg_mgx),
        .dt_bit_shift (dt_bit_shift),
        .dt_sample_x  (dt_sample_x),
        .dt_overflow  (dt_overflow),
        .lb_we        (lb_we),
        .lb_addr      (lb_addr),
        .lb_wdata     (lb_wdata),
        .collision    (collision)
    );

    // Divide-table stand-in: three register stages.
    logic [7:0] d1, d2, d3;
    always @(posedge clk) begin
        d1 <= dt_x;
        d2 <= d1;
        d3 <= d2;
    end
    assign dt_sample_x = d3[7:1];
    assign dt_overflow = (d3 >= 8'd32);

    typedef struct {
        bit         clr;
        logic [8:0] x;
        logic [15:0] pat;
        logic [3:0] col;
        logic [7:0] mg;
        logic [1:0] bs;
        int         nw;
        bit         coll;
        bit         lat;
        bit         restart;
    } vec_t;

    vec_t        vecs [6];
    logic [11:0] exp_q [$];
    bit [255:0]  mb;
    int          nvec = 0;
    int          nmis = 0;
    int          cyc = 0;
    int          wr_cnt = 0;
    int          dn_cnt = 0;
    int          first_iss = -1;
    int          first_we = -1;
    bit          sb_off = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int req);
        nvec++;
        if (act !== req) begin
            nmis++;
            $display("FAIL %s: got %0d, expected %0d", name, act, req);
        end
    endtask

    // Scoreboard consumer.
    always @(negedge clk) begin
        if (done) dn_cnt++;
        if (busy && first_iss < 0) first_iss = cyc;
        if (lb_we && !sb_off) begin
            wr_cnt++;
            if (first_we < 0) first_we = cyc;
            if (exp_q.size() == 0) begin
                chk("unexpected_write_addr", int'(lb_addr), -1);
            end else begin
                logic [11:0] e;
                e = exp_q.pop_front();
                chk("write_addr_data", int'({lb_addr, lb_wdata}), int'(e));
            end
        end
    end

    task automatic model_sprite(input logic [8:0] x, input logic [15:0] pat, input logic [3:0] col);
        for (int o = 0; o < 256; o++) begin
            int d;
            logic [7:0] a;
            d = int'(x) + o;
            a = d[7:0];
            if (o >= 32) break;
            if (d < 256 && pat[15 - (o >> 1)] && col != 4'd0) begin
                if (!mb[a]) begin
                    mb[a] = 1'b1;
                    exp_q.push_back({a, col});
                end
            end
            if (d >= 255) break;
        end
    endtask

    task automatic pulse_clear();
        line_clear = 1'b1;
        mb = '0;
        @(posedge clk); #1;
        line_clear = 1'b0;
    endtask

    task automatic run_sprite(input vec_t v, input string tag);
        int waitc;
        if (v.clr) pulse_clear();
        model_sprite(v.x, v.pat, v.col);
        wr_cnt = 0; dn_cnt = 0; first_iss = -1; first_we = -1;
        sprite_x = v.x; pattern = v.pat; sprite_color = v.col;
        mgx = v.mg; bit_shift = v.bs; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        if (v.restart) begin
            repeat (3) @(posedge clk);
            #1;
            start = 1'b1; sprite_x = 9'd0; sprite_color = 4'd7; mgx = 8'hEE; bit_shift = 2'd3;
            @(posedge clk); #1;
            start = 1'b0;
        end
        waitc = 0;
        while (dn_cnt == 0 && waitc < 400) begin
            @(posedge clk); #1;
            waitc++;
        end
        repeat (3) @(posedge clk);
        #1;
        chk({tag, "_done_pulses"}, dn_cnt, 1);
        chk({tag, "_write_count"}, wr_cnt, v.nw);
        chk({tag, "_missing_writes"}, exp_q.size(), 0);
        chk({tag, "_collision"}, int'(collision), int'(v.coll));
        chk({tag, "_busy_after"}, int'(busy), 0);
        chk({tag, "_mgx_latched"}, int'(dt_reg_mgx), int'(v.mg));
        chk({tag, "_bit_shift_latched"}, int'(dt_bit_shift), int'(v.bs));
        if (v.lat) chk({tag, "_first_write_latency"}, first_we - first_iss, 4);
        exp_q.delete();
    endtask

    initial begin
        reset = 1'b1; line_clear = 1'b0; start = 1'b0;
        sprite_x = '0; sprite_color = '0; pattern = '0; mgx = '0; bit_shift = '0;
        mb = '0;

        vecs[0] = '{1'b1, 9'd10,  16'hFFFF, 4'd5, 8'h11, 2'd1, 32, 1'b0, 1'b1, 1'b0};
        vecs[1] = '{1'b1, 9'd10,  16'h8001, 4'd5, 8'h22, 2'd2,  4, 1'b0, 1'b1, 1'b0};
        vecs[2] = '{1'b1, 9'd250, 16'hFFFF, 4'd5, 8'h33, 2'd3,  6, 1'b0, 1'b1, 1'b0};
        vecs[3] = '{1'b1, 9'd20,  16'hFFFF, 4'd3, 8'h44, 2'd0, 32, 1'b0, 1'b1, 1'b0};
        vecs[4] = '{1'b0, 9'd28,  16'hFFFF, 4'd9, 8'h55, 2'd1,  8, 1'b1, 1'b0, 1'b0};
        vecs[5] = '{1'b1, 9'd100, 16'hFFFF, 4'd0, 8'h66, 2'd2,  0, 1'b0, 1'b0, 1'b1};

        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        chk("reset_busy", int'(busy), 0);
        chk("reset_done", int'(done), 0);
        chk("reset_lb_we", int'(lb_we), 0);
        chk("reset_collision", int'(collision), 0);
        chk("reset_dt_x", int'(dt_x), 0);
        chk("reset_lb_addr_wdata", int'({lb_addr, lb_wdata}), 0);
        chk("reset_dt_regs", int'({dt_reg_mgx, dt_bit_shift}), 0);

        for (int i = 0; i < 6; i++) begin
            run_sprite(vecs[i], $sformatf("vec%0d", i));
        end

        // Reset in the middle of a sprite: abort with no done, bitmap forgotten.
        pulse_clear();
        sb_off = 1'b1;
        dn_cnt = 0;
        sprite_x = 9'd10; pattern = 16'hFFFF; sprite_color = 4'd5; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        chk("abort_busy", int'(busy), 0);
        chk("abort_lb_we", int'(lb_we), 0);
        repeat (20) @(posedge clk);
        #1;
        chk("abort_no_done", dn_cnt, 0);
        chk("abort_no_busy_later", int'(busy), 0);
        sb_off = 1'b0;
        exp_q.delete();
        mb = '0;
        run_sprite('{1'b0, 9'd10, 16'hFFFF, 4'd5, 8'h77, 2'd1, 32, 1'b0, 1'b1, 1'b0}, "after_reset");

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end

endmodule

// File: doc/vdp_sprite_line_renderer.md
Name: vdp_sprite_line_renderer

Overview:
Downstream consumer and driver of vdp_sprite_divide_table. For one sprite at a time, it does the following:
- Sweeps the horizontal offset x into the divide table.
- Aligns the returned sample_x/overflow with its own 3-stage tag pipeline.
- Selects the pattern dot and writes opaque dots into the sprite line buffer.

It also enforces sprite priority through a per-line occupancy bitmap and flags collisions. It sits between the sprite attribute/pattern fetch stage and the line buffer.

Parameters:
DT_LATENCY, 3, clocks from dt_x presented to dt_sample_x/dt_overflow valid
PAT_W, 16, pattern dots per sprite line (dot index = sample_x)
COLOR_W, 4, color/line-buffer data width

Ports:
clk  in  1  system clock (85.90908 MHz)
reset  in  1  synchronous, active-high reset
line_clear  in  1  pulse: clear occupancy bitmap and collision flag (start of line)
start  in  1  pulse: render one sprite; ignored unless idle
sprite_x  in  9  sprite left edge, 0..511; destinations >255 are off-screen
sprite_color  in  COLOR_W  color of opaque dots (0 = transparent sprite)
pattern  in  PAT_W  dot bits, bit (PAT_W-1) = leftmost dot
mgx  in  8  magnification register, forwarded
bit_shift  in  2  forwarded to divide table
busy  out  1  high from the cycle after an accepted start until done
done  out  1  one-cycle pulse at end of sprite
dt_x  out  8  offset to divide table
dt_reg_mgx  out  8  latched mgx
dt_bit_shift  out  2  latched bit_shift
dt_sample_x  in  7  divide table result
dt_overflow  in  1  divide table past-end flag
lb_we  out  1  line buffer write strobe
lb_addr  out  8  line buffer address
lb_wdata  out  COLOR_W  written color
collision  out  1  sticky: opaque dot hit an occupied pixel; cleared by line_clear/reset

Behaviour:
- Reset values: all outputs 0, FSM IDLE, occupancy bitmap all 0, tag pipeline invalid.
- Reset mid-operation aborts the sprite immediately. No done pulse is generated.
- On start in IDLE, latch sprite_x, sprite_color, pattern, mgx and bit_shift, then go to RUN.
- FSM IDLE -> RUN:
  - In RUN, present offset o = 0, 1, 2, ... on dt_x, one per clock.
  - Each issued offset pushes a tag {valid, dest = sprite_x + o (9 bit)} into a DT_LATENCY-deep shift register.
- RUN -> DRAIN on the first of the following:
  - A valid returned dt_overflow.
  - A returned dt_sample_x >= PAT_W.
  - Issued dest reaches 255.
  - Offset 255 has been issued.
- On a terminating result, invalidate all younger in-flight tags; they produce no writes.
- DRAIN -> DONE once every tag is invalid. DONE pulses done for one cycle and returns to IDLE.
- Result handling, for a result with a valid tag, not overflow, sample_x < PAT_W and dest < 256:
  - The dot is opaque if pattern[PAT_W-1-sample_x] = 1 and sprite_color != 0.
- Write rule for an opaque dot:
  - If occupancy[dest] = 0: set it and assert lb_we with lb_addr = dest[7:0] and lb_wdata = color.
  - If occupancy[dest] = 1: no write (the earlier sprite wins) and set collision.
- Latency: for an offset presented on dt_x in cycle n, the result is consumed in cycle n+3 and lb_we is registered and visible in cycle n+4.
- A start during busy is ignored.
- line_clear during busy: the clear takes priority for the bitmap in that cycle. A write in the same cycle still sets its bit. The collision flag is cleared.
- Widths: dest is a 9-bit unsigned sum; overflow past 511 cannot occur because issuing stops at dest 255.

Decomposition:
- vdp_sprite_pkg holds:
  - FSM enum (ST_IDLE, ST_RUN, ST_DRAIN, ST_DONE).
  - DT_LATENCY.
  - Tag struct {valid, dest[8:0]}.
- Sub-module vdp_sprite_occupancy: a 256-bit bitmap with clear, test-and-set and collision output.
- vdp_sprite_divide_table is instantiated alongside the block at the top level, not inside it.

Test Plan:
- Bench divide-table model uses sample_x = x>>1 and overflow when x >= 32. Stimulus: line_clear, then sprite_x=10, pattern=16'hFFFF, color=5 -> 32 writes, addresses 10..41, data 5; first lb_we 4 cycles after the first dt_x; no writes after overflow; one done pulse.
- Same model, pattern=16'h8001 -> writes only at addresses 10, 11, 40, 41.
- sprite_x=250, pattern=16'hFFFF -> writes at 250..255 only; RUN ends when dest reaches 255; done pulses.
- Sprite A at x=20, then sprite B at x=28 overlapping, no line_clear between -> B skips 28..51 and collision=1; line_clear -> collision=0.
- sprite_color=0 -> no lb_we, done still pulses; a second start asserted during busy is ignored.
- Assert reset during RUN -> next cycle busy=0, lb_we=0, no done; bitmap cleared, so a subsequent render of the same sprite writes all dots.
